firmware_arbiter: RTL and testbench

FIRMWARE_ARBITER -- requirements
Module: firmware_arbiter

---
 rtl/firmware_pkg.sv | 15 +
 rtl/firmware_arbiter.sv | 135 +++++++++++++
 tb/tb_firmware_arbiter.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/firmware_pkg.sv
// Shared definitions for the firmware ROM arbiter: default ROM geometry,
// default starvation bound and the arbiter FSM state type.
package firmware_pkg;

    localparam int FIRMWARE_SIZE = 12288;
    localparam int ADDR_W        = 14;
    localparam int STARVE_LIMIT  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

endpackage

// File: rtl/firmware_arbiter.sv
// Shares one asynchronous-read firmware ROM between CPU single-byte reads and
// a DMA burst engine. The CPU has priority, but the DMA is guaranteed a slot
// after STARVE_LIMIT consecutive CPU grants while it was waiting.
module firmware_arbiter #(
    parameter int FIRMWARE_SIZE = firmware_pkg::FIRMWARE_SIZE,
    parameter int ADDR_W        = firmware_pkg::ADDR_W,
    parameter int STARVE_LIMIT  = firmware_pkg::STARVE_LIMIT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_gnt,
    output logic [7:0]        cpu_data,
    output logic              cpu_valid,
    input  logic              dma_start,
    input  logic [ADDR_W-1:0] dma_base,
    input  logic [ADDR_W-1:0] dma_len,
    output logic              dma_busy,
    output logic              dma_err,
    output logic              dma_valid,
    output logic [7:0]        dma_data,
    input  logic              dma_ready,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [7:0]        rom_data
);
    import firmware_pkg::*;

    localparam int                  STARVE_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
    localparam logic [ADDR_W:0]     SIZE_EXT   = (ADDR_W + 1)'(FIRMWARE_SIZE);

    arb_state_t          state;
    logic [ADDR_W-1:0]   pointer;
    logic [ADDR_W-1:0]   remaining;
    logic [STARVE_W-1:0] starve;
    logic                dma_want;
    logic                dma_gnt;
    logic                cpu_oob;
    logic [ADDR_W:0]     burst_end;

    assign cpu_oob   = {1'b0, cpu_addr} >= SIZE_EXT;
    assign burst_end = {1'b0, dma_base} + {1'b0, dma_len};
    assign dma_busy  = (state != IDLE);

    // Grant decision and ROM address mux: CPU wins unless the DMA has been starved to the limit.
    always_comb begin
        dma_want = (state == BURST) && (remaining != '0) && (!dma_valid || dma_ready);
        cpu_gnt  = cpu_req && !(dma_want && (starve == STARVE_MAX));
        dma_gnt  = !cpu_gnt && dma_want;
        if (cpu_gnt) begin
            rom_address = cpu_addr;
        end else if (dma_gnt) begin
            rom_address = pointer;
        end else begin
            rom_address = '0;
        end
    end

    // Starvation counter: counts CPU grants that pushed a waiting DMA aside.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve <= '0;
        end else if (dma_want && cpu_gnt) begin
            if (starve != STARVE_MAX) begin
                starve <= starve + STARVE_W'(1);
            end
        end else begin
            starve <= '0;
        end
    end

    // CPU read return path: one-cycle valid pulse, out-of-range reads return 0xFF.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_valid <= 1'b0;
            cpu_data  <= 8'h00;
        end else begin
            cpu_valid <= cpu_gnt;
            if (cpu_gnt) begin
                cpu_data <= cpu_oob ? 8'hFF : rom_data;
            end
        end
    end

    // DMA burst FSM with its address/count registers and the output data stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pointer   <= '0;
            remaining <= '0;
            dma_valid <= 1'b0;
            dma_data  <= 8'h00;
            dma_err   <= 1'b0;
        end else begin
            if (dma_gnt) begin
                pointer   <= pointer + ADDR_W'(1);
                remaining <= remaining - ADDR_W'(1);
                dma_data  <= rom_data;
                dma_valid <= 1'b1;
            end else if (dma_valid && dma_ready) begin
                dma_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (dma_start && (dma_len != '0)) begin
                        if (burst_end > SIZE_EXT) begin
                            dma_err <= 1'b1;
                        end else begin
                            dma_err   <= 1'b0;
                            pointer   <= dma_base;
                            remaining <= dma_len;
                            state     <= BURST;
                        end
                    end
                end
                BURST: begin
                    if (dma_gnt && (remaining == ADDR_W'(1))) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (dma_valid && dma_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_firmware_arbiter.sv
// Self-checking bench for firmware_arbiter: a transaction-level reference model
// (queue of pending burst addresses, expected CPU return) checks every port every
// cycle, with directed tables and sequences layered on top.
module tb_firmware_arbiter;

    localparam int SIZE  = 12288;
    localparam int AW    = 14;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          cpu_req = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic          cpu_gnt;
    logic [7:0]    cpu_data;
    logic          cpu_valid;
    logic          dma_start = 1'b0;
    logic [AW-1:0] dma_base = '0;
    logic [AW-1:0] dma_len = '0;
    logic          dma_busy;
    logic          dma_err;
    logic          dma_valid;
    logic [7:0]    dma_data;
    logic          dma_ready = 1'b0;
    logic [AW-1:0] rom_address;
    logic [7:0]    rom_data;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state
    logic          m_busy, m_valid, m_err, m_cvalid;
    logic [7:0]    m_data, m_cdata;
    int            starve;
    logic [AW-1:0] pend[$];
    logic          seen_gnt, last_cg;
    logic [AW-1:0] seen_rom;

    typedef struct { logic [AW-1:0] addr; logic [7:0] data; } cpu_vec_t;
    typedef struct { logic [AW-1:0] base; logic [AW-1:0] len; logic err; logic busy; } start_vec_t;

    cpu_vec_t   cpu_tbl[5];
    start_vec_t start_tbl[5];

    firmware_arbiter #(
        .FIRMWARE_SIZE(SIZE),
        .ADDR_W(AW),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_gnt(cpu_gnt),
        .cpu_data(cpu_data), .cpu_valid(cpu_valid),
        .dma_start(dma_start), .dma_base(dma_base), .dma_len(dma_len),
        .dma_busy(dma_busy), .dma_err(dma_err), .dma_valid(dma_valid),
        .dma_data(dma_data), .dma_ready(dma_ready),
        .rom_address(rom_address), .rom_data(rom_data)
    );

    always #5 clk = ~clk;

    // Firmware image contents; 0x0010 holds 0xA9, everything else a simple hash.
    function automatic logic [7:0] rom_byte(input logic [AW-1:0] a);
        int v;
        v = int'(a);
        if (v >= SIZE) return 8'h00;
        if (v == 'h10) return 8'hA9;
        return 8'(((v * 7) + (v >> 5)) ^ 'h3C);
    endfunction

    assign rom_data = rom_byte(rom_address);

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic resetModel();
        m_busy = 1'b0; m_valid = 1'b0; m_err = 1'b0; m_cvalid = 1'b0;
        m_data = 8'h00; m_cdata = 8'h00; starve = 0; last_cg = 1'b0;
        pend.delete();
    endtask

    // Called at a falling edge: drives one cycle of inputs, checks the grant
    // decision mid-cycle, advances the model and checks registered outputs at
    // the next falling edge.
    task automatic applyStimulus(input logic req, input logic [AW-1:0] addr, input logic start,
                                 input logic [AW-1:0] base, input logic [AW-1:0] len,
                                 input logic ready);
        logic          want, cg, dg, acc;
        int            pre;
        logic [AW:0]   sum;
        logic [AW-1:0] exp_rom;
        cpu_req = req; cpu_addr = addr; dma_start = start;
        dma_base = base; dma_len = len; dma_ready = ready;
        #1;
        pre  = pend.size();
        want = m_busy && (pre > 0) && (!m_valid || ready);
        cg   = req && !(want && (starve == LIMIT));
        dg   = !cg && want;
        seen_gnt = cpu_gnt; seen_rom = rom_address; last_cg = cg;
        checkOutput("cpu_gnt", 32'(cpu_gnt), 32'(cg));
        if (!(cg && int'(addr) >= SIZE)) begin
            exp_rom = cg ? addr : (dg ? pend[0] : '0);
            checkOutput("rom_address", 32'(rom_address), 32'(exp_rom));
        end
        acc = m_valid && ready;
        m_cvalid = cg;
        if (cg) m_cdata = (int'(addr) >= SIZE) ? 8'hFF : rom_byte(addr);
        if (dg) begin
            m_data  = rom_byte(pend.pop_front());
            m_valid = 1'b1;
        end else if (acc) begin
            m_valid = 1'b0;
        end
        if (want && cg) starve = (starve < LIMIT) ? starve + 1 : LIMIT;
        else            starve = 0;
        if (!m_busy) begin
            if (start && len != '0) begin
                sum = {1'b0, base} + {1'b0, len};
                if (int'(sum) > SIZE) begin
                    m_err = 1'b1;
                end else begin
                    m_err  = 1'b0;
                    m_busy = 1'b1;
                    for (int i = 0; i < int'(len); i++) pend.push_back(AW'(int'(base) + i));
                end
            end
        end else if (acc && pre == 0) begin
            m_busy = 1'b0;
        end
        @(negedge clk);
        checkOutput("cpu_valid", 32'(cpu_valid), 32'(m_cvalid));
        checkOutput("cpu_data",  32'(cpu_data),  32'(m_cdata));
        checkOutput("dma_valid", 32'(dma_valid), 32'(m_valid));
        checkOutput("dma_data",  32'(dma_data),  32'(m_data));
        checkOutput("dma_busy",  32'(dma_busy),  32'(m_busy));
        checkOutput("dma_err",   32'(dma_err),   32'(m_err));
    endtask

    task automatic drainIdle();
        int n;
        n = 0;
        while (dma_busy && n < 200) begin
            applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1);
            n++;
        end
        checkOutput("drain_idle", 32'(dma_busy), 32'd0);
    endtask

    // Full-throughput burst: bytes on consecutive cycles, busy drops after the last acceptance.
    task automatic runBurst(input logic [AW-1:0] base, input int len, input string tag);
        int nbytes, cyc;
        applyStimulus(1'b0, '0, 1'b1, base, AW'(len), 1'b1);
        nbytes = 0; cyc = 1;
        while (nbytes < len && cyc < len + 20) begin
            applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1);
            cyc++;
            if (dma_valid) begin
                checkOutput({tag, "_byte"}, 32'(dma_data), 32'(rom_byte(AW'(int'(base) + nbytes))));
                nbytes++;
            end
        end
        checkOutput({tag, "_count"}, 32'(nbytes), 32'(len));
        checkOutput({tag, "_cycles"}, 32'(cyc), 32'(len + 1));
        checkOutput({tag, "_busy_last"}, 32'(dma_busy), 32'd1);
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1);
        checkOutput({tag, "_busy_fall"}, 32'(dma_busy), 32'd0);
    endtask

    initial begin
        logic          r_req;
        logic [AW-1:0] r_addr;

        cpu_tbl[0] = '{14'h0010, 8'hA9};
        cpu_tbl[1] = '{14'h3000, 8'hFF};
        cpu_tbl[2] = '{14'h3FFF, 8'hFF};
        cpu_tbl[3] = '{14'h2FFF, rom_byte(14'h2FFF)};
        cpu_tbl[4] = '{14'h0000, rom_byte(14'h0000)};

        start_tbl[0] = '{14'h2FFE, 14'd3, 1'b1, 1'b0};
        start_tbl[1] = '{14'h0050, 14'd0, 1'b1, 1'b0};
        start_tbl[2] = '{14'h2FFE, 14'd2, 1'b0, 1'b1};
        start_tbl[3] = '{14'h3FFF, 14'd5, 1'b1, 1'b0};
        start_tbl[4] = '{14'h0000, 14'd1, 1'b0, 1'b1};

        resetModel();
        $display("[TB] reset check");
        #1 rst_n = 1'b0;
        #2;
        checkOutput("rst_cpu_valid", 32'(cpu_valid), 32'd0);
        checkOutput("rst_dma_busy",  32'(dma_busy),  32'd0);
        checkOutput("rst_dma_valid", 32'(dma_valid), 32'd0);
        checkOutput("rst_dma_err",   32'(dma_err),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] CPU read table");
        foreach (cpu_tbl[k]) begin
            applyStimulus(1'b1, cpu_tbl[k].addr, 1'b0, '0, '0, 1'b1);
            checkOutput("tbl_cpu_gnt",   32'(seen_gnt),  32'd1);
            checkOutput("tbl_cpu_valid", 32'(cpu_valid), 32'd1);
            checkOutput("tbl_cpu_data",  32'(cpu_data),  32'(cpu_tbl[k].data));
            applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1);
            checkOutput("tbl_cpu_pulse", 32'(cpu_valid), 32'd0);
        end

        $display("[TB] basic burst");
        runBurst(14'h0100, 4, "burst4");

        $display("[TB] dma_start range table");
        foreach (start_tbl[k]) begin
            applyStimulus(1'b0, '0, 1'b1, start_tbl[k].base, start_tbl[k].len, 1'b1);
            checkOutput("tbl_dma_err",  32'(dma_err),  32'(start_tbl[k].err));
            checkOutput("tbl_dma_busy", 32'(dma_busy), 32'(start_tbl[k].busy));
            drainIdle();
        end

        $display("[TB] starvation pattern");
        applyStimulus(1'b1, 14'h0020, 1'b1, 14'h0200, 14'd10, 1'b1);
        for (int i = 0; i < 50; i++) begin
            applyStimulus(1'b1, AW'($urandom_range(0, SIZE - 1)), 1'b0, '0, '0, 1'b1);
            checkOutput("starve_pattern", 32'(seen_gnt), 32'((i % 5) != 4));
        end
        drainIdle();

        $display("[TB] back-pressure hold");
        applyStimulus(1'b0, '0, 1'b1, 14'h0300, 14'd6, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);
            checkOutput("stall_no_grant", 32'(seen_rom),  32'd0);
            checkOutput("stall_valid",    32'(dma_valid), 32'd1);
            checkOutput("stall_data",     32'(dma_data),  32'(rom_byte(14'h0301)));
        end
        drainIdle();

        $display("[TB] reset mid-burst");
        applyStimulus(1'b0, '0, 1'b1, 14'h0400, 14'd8, 1'b1);
        applyStimulus(1'b1, 14'h0010, 1'b0, '0, '0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1);
        checkOutput("pre_reset_busy", 32'(dma_busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_busy",      32'(dma_busy),    32'd0);
        checkOutput("mid_rst_dma_valid", 32'(dma_valid),   32'd0);
        checkOutput("mid_rst_dma_data",  32'(dma_data),    32'd0);
        checkOutput("mid_rst_cpu_valid", 32'(cpu_valid),   32'd0);
        checkOutput("mid_rst_cpu_data",  32'(cpu_data),    32'd0);
        checkOutput("mid_rst_dma_err",   32'(dma_err),     32'd0);
        checkOutput("mid_rst_rom_addr",  32'(rom_address), 32'd0);
        checkOutput("mid_rst_cpu_gnt",   32'(cpu_gnt),     32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        resetModel();
        runBurst(14'h0010, 2, "post_reset");

        $display("[TB] randomized traffic");
        r_req = 1'b0; r_addr = '0;
        for (int i = 0; i < 1500; i++) begin
            if (!(r_req && !last_cg)) begin
                r_req  = 1'($urandom_range(0, 1));
                r_addr = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(SIZE, 16383))
                                                     : AW'($urandom_range(0, SIZE - 1));
            end
            applyStimulus(r_req, r_addr, ($urandom_range(0, 11) == 0),
                          AW'($urandom_range(0, SIZE + 200)), AW'($urandom_range(0, 24)),
                          ($urandom_range(0, 3) != 0));
        end
        drainIdle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
